// File: rtl/thermometer_codec_top.sv
// Selectable binary<->thermometer converter between the switch bank and the LED bank.
// One registered result per clock; sel picks encode (0) or decode (1).
module thermometer_codec_top #(
  parameter int unsigned K = 3,
  parameter int unsigned W = 2**K - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw,
  input  logic         sel,
  output logic [W-1:0] led
);

  logic [K-1:0] bin_in;
  logic [W-1:0] enc_c;
  logic [K-1:0] run_cnt;
  logic         run_alive;
  logic [W-1:0] dec_c;
  logic [W-1:0] result_c;

  assign bin_in = sw[K-1:0];

  // Encode: bit i is set when i is below the binary count.
  always_comb begin
    enc_c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      enc_c[i] = (K'(i) < bin_in);
    end
  end

  // Decode: length of the unbroken run of ones starting at bit 0.
  always_comb begin
    run_alive = 1'b1;
    run_cnt   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      run_alive = run_alive & sw[i];
      run_cnt   = run_cnt + K'(run_alive);
    end
  end

  always_comb begin
    dec_c          = '0;
    dec_c[K-1:0]   = run_cnt;
  end

  assign result_c = sel ? dec_c : enc_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= result_c;
    end
  end

endmodule

// File: tb/tb_thermometer_codec_top.sv
// Self-checking bench for thermometer_codec_top: directed cases, sweeps and
// randomized traffic against an arithmetic reference model.
module tb_thermometer_codec_top;

  localparam int unsigned K = 3;
  localparam int unsigned W = 7;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw;
  logic         sel;
  logic [W-1:0] led;

  int checks;
  int errors;

  thermometer_codec_top #(.K(K), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .sel   (sel),
    .led   (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: encode = 2^n - 1; decode = number of leading ones from bit 0.
  function automatic logic [W-1:0] model(input int unsigned s, input bit m);
    int unsigned n;
    int unsigned c;
    if (!m) begin
      n = s % (2**K);
      return W'((1 << n) - 1);
    end
    c = 0;
    while (c < W && ((s >> c) % 2) == 1) c++;
    return W'(c);
  endfunction

  task automatic apply(input logic [W-1:0] s, input logic m);
    @(negedge clk);
    sw  = s;
    sel = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    sw  = 7'b1111111;
    sel = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_async led=%b expected=%b", led, 7'b0000000);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (led !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_hold led=%b expected=%b", led, 7'b0000000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (led !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_release led=%b expected=%b", led, 7'b1111111);
    end
  endtask

  task automatic test_encode_sweep;
    logic [W-1:0] exp;
    for (int i = 0; i < 128; i++) begin
      apply(W'(i), 1'b0);
      exp = model(i, 1'b0);
      checks++;
      if (led !== exp) begin
        errors++;
        $display("FAIL encode_sweep sw=%b led=%b expected=%b", W'(i), led, exp);
      end
    end
  endtask

  task automatic test_decode_directed;
    logic [W-1:0] ins  [6];
    logic [W-1:0] outs [6];
    ins[0] = 7'b0000000; outs[0] = 7'b0000000;
    ins[1] = 7'b0011111; outs[1] = 7'b0000101;
    ins[2] = 7'b1111111; outs[2] = 7'b0000111;
    ins[3] = 7'b1110111; outs[3] = 7'b0000011;
    ins[4] = 7'b1111110; outs[4] = 7'b0000000;
    ins[5] = 7'b0000001; outs[5] = 7'b0000001;
    for (int i = 0; i < 6; i++) begin
      apply(ins[i], 1'b1);
      checks++;
      if (led !== outs[i]) begin
        errors++;
        $display("FAIL decode_directed sw=%b led=%b expected=%b", ins[i], led, outs[i]);
      end
    end
  endtask

  task automatic test_mode_switch;
    logic [W-1:0] exp;
    apply(7'b0000011, 1'b0);
    checks++;
    if (led !== 7'b0000111) begin
      errors++;
      $display("FAIL mode_enc led=%b expected=%b", led, 7'b0000111);
    end
    apply(7'b0000000, 1'b1);
    checks++;
    if (led !== 7'b0000000) begin
      errors++;
      $display("FAIL mode_dec led=%b expected=%b", led, 7'b0000000);
    end
    for (int i = 0; i < 128; i++) begin
      apply(W'(i), 1'b1);
      exp = model(i, 1'b1);
      checks++;
      if (led !== exp) begin
        errors++;
        $display("FAIL decode_sweep sw=%b led=%b expected=%b", W'(i), led, exp);
      end
      if (i == 63) begin
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 7'b0000000) begin
          errors++;
          $display("FAIL midrun_reset led=%b expected=%b", led, 7'b0000000);
        end
        #1 rst_n = 1'b1;
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] s;
    logic         m;
    logic [W-1:0] exp;
    for (int i = 0; i < 300; i++) begin
      s = W'($urandom_range(127, 0));
      m = 1'($urandom_range(1, 0));
      apply(s, m);
      exp = model(s, m);
      checks++;
      if (led !== exp) begin
        errors++;
        $display("FAIL random sw=%b sel=%0d led=%b expected=%b", s, m, led, exp);
      end
      #1;
      sw  = W'($urandom_range(127, 0));
      sel = ~sel;
      #1;
      checks++;
      if (led !== exp) begin
        errors++;
        $display("FAIL glitch_hold led=%b expected=%b", led, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    sw     = '0;
    sel    = 1'b0;
    test_reset();
    test_encode_sweep();
    test_decode_directed();
    test_mode_switch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
